// File: rtl/fa_pkg.sv
// fa_pkg: shared result type and 1-bit add function for the full_adder cell.
package fa_pkg;

    typedef struct packed {
        logic carry;
        logic sum;
    } fa_result_t;

    localparam fa_result_t FA_RESET_VAL = '0;

    function automatic fa_result_t fa_add(input logic a, input logic b, input logic c);
        return '{carry: (a & b) | (c & (a ^ b)), sum: a ^ b ^ c};
    endfunction

endpackage

// File: rtl/full_adder_half_adder.sv
// half_adder: 1-bit half adder, built as fa_add with the carry-in tied low.
module half_adder
    import fa_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    fa_result_t w_r;

    assign w_r = fa_add(a, b, 1'b0);
    assign s   = w_r.sum;
    assign c   = w_r.carry;

endmodule

// File: rtl/full_adder.sv
// full_adder: registered carry-save cell built from two half adders and an OR.
// Define FULL_ADDER_ASSERT_EN to compile in the simulation assertions.
module full_adder
    import fa_pkg::*;
(
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic a_in,
    input  logic b_in,
    input  logic c_in,
    output logic s_out,
    output logic c_out
);

    logic       w_s0;
    logic       w_c0;
    logic       w_s1;
    logic       w_c1;
    fa_result_t w_sum;
    fa_result_t r_q;

    half_adder u_ha0 (.a(a_in), .b(b_in), .s(w_s0), .c(w_c0));
    half_adder u_ha1 (.a(w_s0), .b(c_in), .s(w_s1), .c(w_c1));

    assign w_sum = '{carry: w_c0 | w_c1, sum: w_s1};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_q <= FA_RESET_VAL;
        else           r_q <= w_sum;
    end

    assign s_out = r_q.sum;
    assign c_out = r_q.carry;

`ifdef FULL_ADDER_ASSERT_EN
    // The first edge after release still shows the reset value, so it is skipped.
    a_sum: assert property (@(posedge clk_in) disable iff (!rst_n_in)
        $past(rst_n_in) |-> {c_out, s_out} == $past(fa_add(a_in, b_in, c_in)))
        else $error("full_adder: registered sum does not match previous inputs");

    a_rst: assert property (@(posedge clk_in) !rst_n_in |-> {c_out, s_out} == 2'b00)
        else $error("full_adder: outputs not zero during reset");
`else
`endif

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed vector bench for the registered full adder.
module tb_full_adder;

    logic clk_in = 1'b0;
    logic rst_n_in = 1'b1;
    logic a_in = 1'b0;
    logic b_in = 1'b0;
    logic c_in = 1'b0;
    logic s_out;
    logic c_out;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] abc;
        logic [1:0] exp;
    } vec_t;

    vec_t vecs[8];

    full_adder dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .a_in(a_in), .b_in(b_in), .c_in(c_in),
        .s_out(s_out), .c_out(c_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [1:0] exp);
        checks++;
        if ({c_out, s_out} !== exp) begin
            failures++;
            $display("FAIL %s: got {c,s}=%b expected %b at %0t", name, {c_out, s_out}, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] abc);
        {a_in, b_in, c_in} = abc;
    endtask

    initial begin
        vecs[0] = '{3'b000, 2'b00};
        vecs[1] = '{3'b100, 2'b01};
        vecs[2] = '{3'b010, 2'b01};
        vecs[3] = '{3'b110, 2'b10};
        vecs[4] = '{3'b001, 2'b01};
        vecs[5] = '{3'b101, 2'b10};
        vecs[6] = '{3'b011, 2'b10};
        vecs[7] = '{3'b111, 2'b11};

        drive(3'b111);
        #2 rst_n_in = 1'b0;
        #1 check("reset_async_assert", 2'b00);
        repeat (2) @(posedge clk_in);
        #1 check("reset_hold_with_clock", 2'b00);
        @(negedge clk_in) rst_n_in = 1'b1;
        #1 check("reset_release_no_edge", 2'b00);
        @(posedge clk_in);
        #1 check("reset_release_first_edge", 2'b11);

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].abc);
            @(posedge clk_in);
            #1 check($sformatf("sweep_%b", vecs[i].abc), vecs[i].exp);
        end

        for (int i = 0; i < 8; i++) begin
            drive(i[0] ? 3'b111 : 3'b000);
            #3 check($sformatf("toggle_prev_%0d", i), i[0] ? 2'b00 : 2'b11);
            @(posedge clk_in);
            #1 check($sformatf("toggle_%0d", i), i[0] ? 2'b11 : 2'b00);
        end

        drive(3'b110);
        @(posedge clk_in);
        #1 check("midreset_before", 2'b10);
        #1 rst_n_in = 1'b0;
        #1 check("midreset_async_drop", 2'b00);
        #1 rst_n_in = 1'b1;
        #4 check("midreset_hold_till_edge", 2'b00);
        @(posedge clk_in);
        #1 check("midreset_restore", 2'b10);

        drive(3'b011);
        @(posedge clk_in);
        #1 check("setup_initial", 2'b10);
        @(negedge clk_in) drive(3'b100);
        #1 check("setup_hold_between_edges", 2'b10);
        #3 check("setup_hold_near_edge", 2'b10);
        @(posedge clk_in);
        #1 check("setup_after_edge", 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
